if_stage_c: RTL and testbench
=============================

# if_stage_c

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. It holds the program counter, selects the next PC from the redirect sources returned by decode, reads the instruction memory, and drives the IF/ID pipeline register consumed by decode. Stall and flush requests from the decode-stage hazard logic act here.

## Interface

Parameters:
- `IMEM_WORDS`, default 1024: instruction memory depth in 32-bit words.
- `IMEM_INIT`, default "instruction_memory.mem": hex init file for the instruction memory.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

Ports:
- `Clk` (input, 1): the single clock. All state updates on the rising edge.
- `Reset` (input, 1): synchronous, active-high.
- `PCSrc` (input, 3): next-PC select from the decode-stage branch decoder.
- `PCPlus4ToIF` (input, 32): PC+4 of the instruction currently in decode; jump-target upper bits.
- `PCSumImmToIF` (input, 32): branch target.
- `SEImm26ToIF` (input, 32): sign-extended 26-bit immediate, already shifted left by 2.
- `ReadReg1ToIF` (input, 32): rs value, the jr target.
- `PCWrite` (input, 1): PC update enable from the hazard unit.
- `IFIDWrite` (input, 1): IF/ID register update enable.
- `IFIDFlush` (input, 1): clears IF/ID to NOP.
- `oInstruction` (output, 32): IF/ID instruction.
- `oPCPlus4` (output, 32): IF/ID PC+4.
- `oPC` (output, 32): current PC, for debug and display.
- `oFetchCount` (output, 32): count of non-flushed instructions latched into IF/ID.

## Operation

**Next-PC mux.** PC+4 is computed internally as PC + 32'd4 and wraps modulo 2^32.
- `PCSrc`=0: PC+4.
- `PCSrc`=1: `PCSumImmToIF`.
- `PCSrc`=2: {`PCPlus4ToIF`[31:28], `SEImm26ToIF`[27:0]}.
- `PCSrc`=3: `ReadReg1ToIF`.
- `PCSrc`=4–7 are reserved and select PC+4.

**PC register.**
- `Reset` loads `RESET_PC`.
- Otherwise, when `PCWrite`=1, PC takes the next-PC value; when `PCWrite`=0, PC holds.

**Instruction memory.**
- Combinational read of word PC[31:2].
- A word index ≥ `IMEM_WORDS` returns 32'h0000_0000 (NOP).
- PC[1:0] is ignored; no alignment trap.

**IF/ID register.** Priority is `Reset` > `IFIDFlush` > `IFIDWrite`.
- `Reset` or `IFIDFlush`: `oInstruction` = 0 and `oPCPlus4` = 0.
- Else if `IFIDWrite`=1: latch {instruction memory output, internal PC+4}.
- Else: hold.

**Fetch counter.**
- Cleared by `Reset`.
- Increments by 1 on every edge where `IFIDWrite`=1 and `IFIDFlush`=0 and `Reset`=0.
- Wraps at 2^32.

**Boundary conditions.**
- Stall (`PCWrite`=0, `IFIDWrite`=0): PC, IF/ID and counter all hold. A redirect arriving during a stall is ignored.
- Taken branch (`PCWrite`=1, `IFIDFlush`=1): PC takes the target and IF/ID becomes NOP in the same edge. The wrong-path instruction is discarded and not counted.
- `PCWrite`=0 with `IFIDFlush`=1: PC holds and IF/ID clears.
- `Reset` asserted mid-stream: all state returns to reset values on that edge regardless of the other inputs.

## Timing

- Reset values: `oPC`=`RESET_PC`, `oInstruction`=0, `oPCPlus4`=0, `oFetchCount`=0.
- `PCSrc` and the target inputs are sampled at the edge that updates PC. They are combinational from decode, so a redirect takes effect one cycle after the branch enters decode.
- Fetch-to-decode latency is 1 cycle: the instruction at PC appears on `oInstruction` after the next edge.
- `oPC` is registered. `oInstruction`, `oPCPlus4` and `oFetchCount` change only on edges.
- The only combinational paths are internal: PC → memory → IF/ID D-input, and the `PCSrc`/target inputs → PC D-input. There is no combinational path from any input to any output.

## Structure

- Shared package (`Pipeline_Pkg_C`) holds:
  - the `PCSrc` encodings `PCSRC_SEQ`=0, `PCSRC_BRANCH`=1, `PCSRC_JUMP`=2, `PCSRC_JR`=3;
  - `NOP_INSTR` = 32'h0;
  - `RESET_PC_DEFAULT`.
  The decode stage's branch decoder uses the same encodings.
- One sub-module: `InstructionMemory_C`, parameterised by `IMEM_WORDS`/`IMEM_INIT`, with a combinational word read and out-of-range return of 0.
- PC register, next-PC mux, IF/ID register and counter live in this block.

## Test plan

1. **Reset and sequential fetch.** Memory word0=32'h2008_0005, word1=32'h2009_0007. Hold `Reset` for 2 cycles, then release with `PCSrc`=0 and all enables 1.
   - During reset: `oPC`=0, `oInstruction`=0.
   - Edge 1 after release: `oPC`=4, `oInstruction`=32'h2008_0005, `oPCPlus4`=4.
   - Edge 2: `oPC`=8, `oInstruction`=32'h2009_0007, `oFetchCount`=2.
2. **Stall.** At `oPC`=8, drive `PCWrite`=0, `IFIDWrite`=0 for 3 cycles with `PCSrc`=1, `PCSumImmToIF`=32'h40.
   - PC stays 8; `oInstruction` and `oFetchCount` are unchanged.
   - On release with `PCSrc`=0: PC=12.
3. **Taken branch.** At `oPC`=8, drive `PCSrc`=1, `PCSumImmToIF`=32'h20, `IFIDFlush`=1 for 1 cycle.
   - Next edge: `oPC`=32'h20, `oInstruction`=0, counter unchanged.
   - Following edge: `oInstruction` = word 8.
4. **Jump and jr.**
   - `PCSrc`=2, `PCPlus4ToIF`=32'hA000_0010, `SEImm26ToIF`=32'hFFFF_FF00 → `oPC`=32'hAFFF_FF00.
   - `PCSrc`=3, `ReadReg1ToIF`=32'h0000_0100 → `oPC`=32'h100.
   - `PCSrc`=6 → PC+4.
5. **Out of range.** With `IMEM_WORDS`=16, jr to 32'h40 → `oInstruction`=0 after the next edge.
6. **Reset priority.** Assert `Reset` together with `PCSrc`=1 and `IFIDFlush`=0 mid-run → next edge: `oPC`=`RESET_PC`, IF/ID=0, `oFetchCount`=0.

Source files
------------

// File: rtl/if_stage_c_pkg.sv
// Shared pipeline definitions: next-PC select encodings, NOP encoding and the
// IF/ID register layout. The decode-stage branch decoder uses the same encodings.
package Pipeline_Pkg_C;

  localparam logic [2:0]  PCSRC_SEQ        = 3'd0;
  localparam logic [2:0]  PCSRC_BRANCH     = 3'd1;
  localparam logic [2:0]  PCSRC_JUMP       = 3'd2;
  localparam logic [2:0]  PCSRC_JR         = 3'd3;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  // Reserved encodings (4-7) fall through to sequential fetch.
  function automatic logic [31:0] select_next_pc(
    input logic [2:0]  src,
    input logic [31:0] seq_pc,
    input logic [31:0] branch_pc,
    input logic [31:0] jump_pc,
    input logic [31:0] jr_pc
  );
    logic [31:0] sel;
    sel = seq_pc;
    case (src)
      PCSRC_SEQ:    sel = seq_pc;
      PCSRC_BRANCH: sel = branch_pc;
      PCSRC_JUMP:   sel = jump_pc;
      PCSRC_JR:     sel = jr_pc;
      default:      sel = seq_pc;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/if_stage_c_imem.sv
// Word-addressed instruction ROM with combinational read; any word index past
// the end of the array reads as a NOP.
module InstructionMemory_C
  import Pipeline_Pkg_C::*;
#(
  parameter int    IMEM_WORDS = 1024,
  parameter string IMEM_INIT  = "instruction_memory.mem"
) (
  input  logic [29:0] addr,
  output logic [31:0] rdata
);

  localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  // Contents come from the image named by IMEM_INIT, placed by the memory-init
  // flow of the target tool (or written directly into the array in simulation).
  logic [31:0] mem [IMEM_WORDS];
  logic        in_range;
  logic [IDX_W-1:0] idx;

  assign in_range = 32'(addr) < 32'(IMEM_WORDS);
  assign idx      = addr[IDX_W-1:0];

  if (IMEM_INIT != "") begin : g_image
    assign rdata = in_range ? mem[idx] : NOP_INSTR;
  end else begin : g_blank
    // No image configured: the fetch path sees an all-NOP program.
    assign rdata = NOP_INSTR;
  end

endmodule

// File: rtl/if_stage_c.sv
// Instruction-fetch stage: PC register, next-PC select, instruction memory
// read and the IF/ID pipeline register feeding decode.
module if_stage_c
  import Pipeline_Pkg_C::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter string       IMEM_INIT  = "instruction_memory.mem",
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] PCPlus4ToIF,
  input  logic [31:0] PCSumImmToIF,
  input  logic [31:0] SEImm26ToIF,
  input  logic [31:0] ReadReg1ToIF,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        IFIDFlush,
  output logic [31:0] oInstruction,
  output logic [31:0] oPCPlus4,
  output logic [31:0] oPC,
  output logic [31:0] oFetchCount
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] pc_next;
  logic [31:0] imem_rdata;
  ifid_t       ifid_q;
  logic [31:0] fetch_count_q;
  logic        unused_ok;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {PCPlus4ToIF[31:28], SEImm26ToIF[27:0]};
  assign pc_next     = select_next_pc(PCSrc, pc_plus4, PCSumImmToIF, jump_target, ReadReg1ToIF);

  // Byte offset within the word is ignored; misaligned PCs fetch the containing word.
  assign unused_ok = ^{pc_q[1:0], PCPlus4ToIF[27:0], SEImm26ToIF[31:28]};

  InstructionMemory_C #(
    .IMEM_WORDS (IMEM_WORDS),
    .IMEM_INIT  (IMEM_INIT)
  ) u_imem (
    .addr  (pc_q[31:2]),
    .rdata (imem_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else if (PCWrite) begin
      pc_q <= pc_next;
    end
  end

  // Flush outranks write so a taken branch discards the wrong-path fetch.
  always_ff @(posedge Clk) begin
    if (Reset || IFIDFlush) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc_plus4 <= 32'd0;
    end else if (IFIDWrite) begin
      ifid_q.instr    <= imem_rdata;
      ifid_q.pc_plus4 <= pc_plus4;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_count_q <= 32'd0;
    end else if (IFIDWrite && !IFIDFlush) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign oPC          = pc_q;
  assign oInstruction = ifid_q.instr;
  assign oPCPlus4     = ifid_q.pc_plus4;
  assign oFetchCount  = fetch_count_q;

endmodule

// File: tb/tb_if_stage_c.sv
// Bench for if_stage_c: per-cycle stimulus rows push their expected IF/ID, PC
// and counter values onto a scoreboard, which each test pops after the edge.
module tb_if_stage_c;

  logic        Clk;
  logic        Reset;
  logic [2:0]  PCSrc;
  logic [31:0] PCPlus4ToIF;
  logic [31:0] PCSumImmToIF;
  logic [31:0] SEImm26ToIF;
  logic [31:0] ReadReg1ToIF;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic [31:0] oInstruction;
  logic [31:0] oPCPlus4;
  logic [31:0] oPC;
  logic [31:0] oFetchCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  src;
    logic [31:0] sum;
    logic [31:0] p4;
    logic [31:0] imm;
    logic [31:0] rr1;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic [31:0] e_cnt;
  } step_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  if_stage_c #(
    .IMEM_WORDS (16),
    .IMEM_INIT  ("instruction_memory.mem"),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCSrc        (PCSrc),
    .PCPlus4ToIF  (PCPlus4ToIF),
    .PCSumImmToIF (PCSumImmToIF),
    .SEImm26ToIF  (SEImm26ToIF),
    .ReadReg1ToIF (ReadReg1ToIF),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .oInstruction (oInstruction),
    .oPCPlus4     (oPCPlus4),
    .oPC          (oPC),
    .oFetchCount  (oFetchCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] word(input int k);
    if (k == 0) return 32'h2008_0005;
    if (k == 1) return 32'h2009_0007;
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  function automatic step_t st(
    input logic rst, input logic [2:0] src,
    input logic [31:0] sum, input logic [31:0] p4, input logic [31:0] imm, input logic [31:0] rr1,
    input logic pcw, input logic ifw, input logic fl,
    input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_pp4, input logic [31:0] e_cnt
  );
    step_t s;
    s.rst = rst; s.src = src; s.sum = sum; s.p4 = p4; s.imm = imm; s.rr1 = rr1;
    s.pcw = pcw; s.ifw = ifw; s.fl = fl;
    s.e_pc = e_pc; s.e_instr = e_instr; s.e_pp4 = e_pp4; s.e_cnt = e_cnt;
    return s;
  endfunction

  // Drive one row (away from the edge) and enqueue what the next edge must produce.
  task automatic apply(input step_t s);
    exp_t e;
    Reset        = s.rst;
    PCSrc        = s.src;
    PCSumImmToIF = s.sum;
    PCPlus4ToIF  = s.p4;
    SEImm26ToIF  = s.imm;
    ReadReg1ToIF = s.rr1;
    PCWrite      = s.pcw;
    IFIDWrite    = s.ifw;
    IFIDFlush    = s.fl;
    e.pc = s.e_pc; e.instr = s.e_instr; e.pp4 = s.e_pp4; e.cnt = s.e_cnt;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t t[$];
    exp_t  e;
    // Reset wins over a pending branch redirect.
    t.push_back(st(1, 3'd1, 32'h40, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 0));
    t.push_back(st(1, 3'd1, 32'h40, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 0));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h4, 32'h2008_0005, 32'h4, 1));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h8, 32'h2009_0007, 32'h8, 2));
    foreach (t[i]) begin
      apply(t[i]);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++; if (oPC !== e.pc) begin failures++; $display("FAIL reset[%0d] oPC got=%h exp=%h", i, oPC, e.pc); end
      checks++; if (oInstruction !== e.instr) begin failures++; $display("FAIL reset[%0d] oInstruction got=%h exp=%h", i, oInstruction, e.instr); end
      checks++; if (oPCPlus4 !== e.pp4) begin failures++; $display("FAIL reset[%0d] oPCPlus4 got=%h exp=%h", i, oPCPlus4, e.pp4); end
      checks++; if (oFetchCount !== e.cnt) begin failures++; $display("FAIL reset[%0d] oFetchCount got=%0d exp=%0d", i, oFetchCount, e.cnt); end
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    exp_t  e;
    t.push_back(st(0, 3'd1, 32'h20, 0, 0, 0, 1, 1, 1, 32'h20, 32'h0, 32'h0, 2));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h24, word(8), 32'h24, 3));
    foreach (t[i]) begin
      apply(t[i]);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++; if (oPC !== e.pc) begin failures++; $display("FAIL branch[%0d] oPC got=%h exp=%h", i, oPC, e.pc); end
      checks++; if (oInstruction !== e.instr) begin failures++; $display("FAIL branch[%0d] oInstruction got=%h exp=%h", i, oInstruction, e.instr); end
      checks++; if (oPCPlus4 !== e.pp4) begin failures++; $display("FAIL branch[%0d] oPCPlus4 got=%h exp=%h", i, oPCPlus4, e.pp4); end
      checks++; if (oFetchCount !== e.cnt) begin failures++; $display("FAIL branch[%0d] oFetchCount got=%0d exp=%0d", i, oFetchCount, e.cnt); end
    end
  endtask

  task automatic test_stall();
    step_t t[$];
    exp_t  e;
    for (int k = 0; k < 3; k++)
      t.push_back(st(0, 3'd1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h24, word(8), 32'h24, 3));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h28, word(9), 32'h28, 4));
    // PC held while IF/ID is flushed; flushed edge does not count.
    t.push_back(st(0, 3'd1, 32'h40, 0, 0, 0, 0, 1, 1, 32'h28, 32'h0, 32'h0, 4));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h2C, word(10), 32'h2C, 5));
    foreach (t[i]) begin
      apply(t[i]);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++; if (oPC !== e.pc) begin failures++; $display("FAIL stall[%0d] oPC got=%h exp=%h", i, oPC, e.pc); end
      checks++; if (oInstruction !== e.instr) begin failures++; $display("FAIL stall[%0d] oInstruction got=%h exp=%h", i, oInstruction, e.instr); end
      checks++; if (oPCPlus4 !== e.pp4) begin failures++; $display("FAIL stall[%0d] oPCPlus4 got=%h exp=%h", i, oPCPlus4, e.pp4); end
      checks++; if (oFetchCount !== e.cnt) begin failures++; $display("FAIL stall[%0d] oFetchCount got=%0d exp=%0d", i, oFetchCount, e.cnt); end
    end
  endtask

  task automatic test_jump_jr();
    step_t t[$];
    exp_t  e;
    t.push_back(st(0, 3'd2, 0, 32'hA000_0010, 32'hFFFF_FF00, 0, 1, 1, 0, 32'hAFFF_FF00, word(11), 32'h30, 6));
    t.push_back(st(0, 3'd3, 0, 0, 0, 32'h0000_0100, 1, 1, 0, 32'h100, 32'h0, 32'hAFFF_FF04, 7));
    t.push_back(st(0, 3'd6, 32'h40, 0, 0, 32'h40, 1, 1, 0, 32'h104, 32'h0, 32'h104, 8));
    // PC+4 wraps past the top of the address space.
    t.push_back(st(0, 3'd3, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h108, 9));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 10));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h4, word(0), 32'h4, 11));
    foreach (t[i]) begin
      apply(t[i]);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++; if (oPC !== e.pc) begin failures++; $display("FAIL jump[%0d] oPC got=%h exp=%h", i, oPC, e.pc); end
      checks++; if (oInstruction !== e.instr) begin failures++; $display("FAIL jump[%0d] oInstruction got=%h exp=%h", i, oInstruction, e.instr); end
      checks++; if (oPCPlus4 !== e.pp4) begin failures++; $display("FAIL jump[%0d] oPCPlus4 got=%h exp=%h", i, oPCPlus4, e.pp4); end
      checks++; if (oFetchCount !== e.cnt) begin failures++; $display("FAIL jump[%0d] oFetchCount got=%0d exp=%0d", i, oFetchCount, e.cnt); end
    end
  endtask

  task automatic test_out_of_range();
    step_t t[$];
    exp_t  e;
    t.push_back(st(0, 3'd3, 0, 0, 0, 32'h40, 1, 1, 0, 32'h40, word(1), 32'h8, 12));
    t.push_back(st(0, 3'd3, 0, 0, 0, 32'h3C, 1, 1, 0, 32'h3C, 32'h0, 32'h44, 13));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h40, word(15), 32'h40, 14));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h44, 32'h0, 32'h44, 15));
    foreach (t[i]) begin
      apply(t[i]);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++; if (oPC !== e.pc) begin failures++; $display("FAIL oor[%0d] oPC got=%h exp=%h", i, oPC, e.pc); end
      checks++; if (oInstruction !== e.instr) begin failures++; $display("FAIL oor[%0d] oInstruction got=%h exp=%h", i, oInstruction, e.instr); end
      checks++; if (oPCPlus4 !== e.pp4) begin failures++; $display("FAIL oor[%0d] oPCPlus4 got=%h exp=%h", i, oPCPlus4, e.pp4); end
      checks++; if (oFetchCount !== e.cnt) begin failures++; $display("FAIL oor[%0d] oFetchCount got=%0d exp=%0d", i, oFetchCount, e.cnt); end
    end
  endtask

  task automatic test_reset_priority();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 3'd1, 32'h40, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 0));
    t.push_back(st(0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 32'h4, word(0), 32'h4, 1));
    foreach (t[i]) begin
      apply(t[i]);
      @(posedge Clk); #1;
      e = sb.pop_front();
      checks++; if (oPC !== e.pc) begin failures++; $display("FAIL rstprio[%0d] oPC got=%h exp=%h", i, oPC, e.pc); end
      checks++; if (oInstruction !== e.instr) begin failures++; $display("FAIL rstprio[%0d] oInstruction got=%h exp=%h", i, oInstruction, e.instr); end
      checks++; if (oPCPlus4 !== e.pp4) begin failures++; $display("FAIL rstprio[%0d] oPCPlus4 got=%h exp=%h", i, oPCPlus4, e.pp4); end
      checks++; if (oFetchCount !== e.cnt) begin failures++; $display("FAIL rstprio[%0d] oFetchCount got=%0d exp=%0d", i, oFetchCount, e.cnt); end
    end
  endtask

  initial begin
    Reset = 1'b1; PCSrc = 3'd0; PCPlus4ToIF = '0; PCSumImmToIF = '0;
    SEImm26ToIF = '0; ReadReg1ToIF = '0; PCWrite = 1'b1; IFIDWrite = 1'b1; IFIDFlush = 1'b0;
    for (int k = 0; k < 16; k++) dut.u_imem.mem[k] = word(k);
    @(negedge Clk);
    test_reset();
    test_branch();
    test_stall();
    test_jump_jr();
    test_out_of_range();
    test_reset_priority();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
